seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial sequence detector. Successor to the lab's fixed two-output single-input FSM.
- Watches a 1-bit serial input `x` for a configurable bit pattern of configurable length.
- Gives both a Mealy match output (same cycle) and a Moore match output (registered, one cycle later).
- Supports overlapping and non-overlapping detection, and keeps a saturating match counter readable by surrounding lab logic.

Parameters:
- PATTERN_LEN, 4, number of bits in the pattern; legal range 2..32 (elaboration error outside this range).
- PATTERN, 4'b1011, pattern value, PATTERN_LEN bits wide; PATTERN[PATTERN_LEN-1] is the first bit received.
- OVERLAP, 1, 1 = bits of a detected match may start the next match; 0 = history is discarded after each match.
- CNT_W, 8, width of match_count.

Ports:
- clock  input  1  rising-edge system clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  bit-valid qualifier; `x` is sampled only when en=1.
- x  input  1  serial data bit.
- clear  input  1  synchronous clear of history, fill count and match_count (en not required).
- y_mealy  output  1  combinational match indication for the current cycle.
- y_moore  output  1  registered match indication, asserted the cycle after the match bit.
- match_count  output  CNT_W  number of matches since reset/clear, saturating.
- busy  output  1  fill>0, i.e. a partial prefix is being tracked.

Behaviour:
- One clock (`clock`). Reset is asynchronous and active-low (`reset_n`).
- Reset (reset_n=0, asynchronous): hist=0, fill=0, y_moore=0, match_count=0, busy=0. y_mealy=0 while in reset.
- State:
  - hist: PATTERN_LEN-1 bits, shift register of the most recent accepted bits.
  - fill: 0..PATTERN_LEN-1, number of valid bits in hist, saturating at PATTERN_LEN-1.
- match_now = en & ~clear & (fill == PATTERN_LEN-1) & ({hist, x} == PATTERN).
- y_mealy = match_now. Combinational from x/en/clear; no registered path is required.
- Accepted bit (en=1, clear=0), on the clock edge:
  - hist <= {hist[PATTERN_LEN-3:0], x}.
  - If match_now and OVERLAP=0: fill <= 0.
  - Otherwise: fill <= min(fill+1, PATTERN_LEN-1).
  - With OVERLAP=1, fill stays saturated after a match, so the next bit can complete another match using the shared bits.
- en=0: hist, fill and match_count hold. y_mealy=0. y_moore becomes 0 on the next edge. Bubbles of any length between bits are transparent to detection.
- y_moore <= match_now every edge. It is high for exactly one cycle per match.
- match_count: increments by 1 on the edge where match_now=1; holds at 2^CNT_W-1 (no wrap).
- clear=1 on an edge: hist<=0, fill<=0, match_count<=0, y_moore<=0. Clear overrides en and x; no match is counted in that cycle.
- Reset mid-pattern: any partial prefix is lost. The first match after reset needs PATTERN_LEN fresh accepted bits.
- Minimum latency: match detectable on the PATTERN_LEN-th accepted bit after reset/clear. y_mealy in that cycle, y_moore and match_count one edge later.
- Patterns with no proper border (e.g. 1000): OVERLAP has no observable effect.
- busy = (fill != 0). It is registered-derived, so it has no combinational dependence on x.

Decomposition:
- Package seq_det_pkg:
  - Function `fill_w(len)` returning $clog2(len).
  - Localparam helpers for CNT_MAX.
  - Function `pattern_border(pattern, len)`, used by the bench's reference model to predict overlapping matches.
- One natural sub-module, sat_counter (parameter W; ports clock, reset_n, inc, clr, q). Used for match_count and reusable elsewhere in the lab set.
- Everything else lives inline in seq_detector_param.

Test Plan:
- PATTERN=1011, OVERLAP=1, en=1, stream 1,0,1,1,0,1,1 → y_mealy high on bits 4 and 7; y_moore high the cycle after each; match_count=2.
- Same stream, OVERLAP=0 → single match on bit 4 only; match_count=1; fill=3 after bit 7.
- Same stream with en=0 for 3 cycles between every bit → identical match positions in accepted-bit order; y_mealy never high while en=0; y_moore pulses exactly one cycle each.
- Feed 1,0,1, assert reset_n=0 for 2 cycles, then feed 1 → no match; then feed 1,0,1,1 → match on the 4th bit; match_count=1.
- CNT_W=2, OVERLAP=1, stream 1011011011011 (4 matches) → match_count sequence 1,2,3,3 (saturates at 3).
- After 2 matches, pulse clear together with en=1 and x completing a third match → no y_mealy, match_count=0, busy=0 on the next cycle.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised serial sequence detector family.
// Width helpers for the fill counter and saturating counters, plus a
// pattern-border helper for predicting overlapping detections.
package seq_det_pkg;

    // Legal pattern length range for seq_detector_param.
    localparam int MIN_PATTERN_LEN = 2;
    localparam int MAX_PATTERN_LEN = 32;

    // Number of bits needed to hold a fill value of 0..len-1.
    function automatic int fill_w(input int len);
        return $clog2(len);
    endfunction

    // Largest value a w-bit saturating counter reaches (w up to 63).
    function automatic longint unsigned cnt_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Length of the longest proper border of the len-bit pattern, i.e. the
    // longest prefix that is also a suffix.  This is how many bits of one
    // match can be reused by the next one when overlap is enabled.
    // The pattern is MSB-first: pattern[len-1] is the first bit received.
    function automatic int pattern_border(input logic [31:0] pattern, input int len);
        logic [31:0] mask;
        logic [31:0] prefix;
        logic [31:0] suffix;
        for (int b = len - 1; b >= 1; b--) begin
            mask   = (32'd1 << b) - 32'd1;
            prefix = (pattern >> (len - b)) & mask;
            suffix = pattern & mask;
            if (prefix == suffix) begin
                return b;
            end
        end
        return 0;
    endfunction

endpackage : seq_det_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low
// reset.  Clear has priority over increment; at all-ones the count holds.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise step up until saturation.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule : sat_counter

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector.  Keeps a shift register of the last
// PATTERN_LEN-1 accepted bits plus a fill count, flags a match combinationally
// (Mealy) on the completing bit and registered (Moore) one cycle later, and
// counts matches in a saturating counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter bit                     OVERLAP     = 1'b1,
    parameter int                     CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             x,
    input  logic             clear,
    output logic             y_mealy,
    output logic             y_moore,
    output logic [CNT_W-1:0] match_count,
    output logic             busy
);

    localparam int              FW       = fill_w(PATTERN_LEN);
    localparam int              HW       = PATTERN_LEN - 1;
    localparam logic [FW-1:0]   FILL_MAX = FW'(PATTERN_LEN - 1);

    // Reject pattern lengths the shift/fill logic is not built for.
    if ((PATTERN_LEN < MIN_PATTERN_LEN) || (PATTERN_LEN > MAX_PATTERN_LEN)) begin : g_len_check
        $error("seq_detector_param: PATTERN_LEN must be in 2..32");
    end

    logic [HW-1:0] hist_q;
    logic [HW-1:0] hist_d;
    logic [HW-1:0] hist_shift;
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;
    logic          y_moore_q;
    logic          match_now;
    logic          accept;

    // A bit is accepted only when qualified and not overridden by clear.
    assign accept = en & ~clear;

    // Match completes when history is full and history plus the incoming bit
    // equals the pattern.  Fill is zero in reset, so this is low in reset.
    assign match_now = accept & (fill_q == FILL_MAX) & ({hist_q, x} == PATTERN);

    // Shifted history: newest bit enters at bit 0, oldest falls off the top.
    assign hist_shift[0] = x;
    for (genvar gi = 1; gi < HW; gi++) begin : g_shift
        assign hist_shift[gi] = hist_q[gi-1];
    end

    // Next history and fill count.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = hist_shift;
            if (match_now && !OVERLAP) begin
                // Non-overlapping: a finished match may not seed the next.
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    // History, fill and Moore output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_q    <= '0;
            fill_q    <= '0;
            y_moore_q <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            y_moore_q <= match_now;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (match_now),
        .clr     (clear),
        .q       (match_count)
    );

    assign y_mealy = match_now;
    assign y_moore = y_moore_q;
    assign busy    = (fill_q != '0);

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param.  Three instances share inputs:
// dut 0 = 1011 overlap, dut 1 = 1011 non-overlap, dut 2 = 1011 overlap with a
// 2-bit counter.  Each issued cycle pushes the hand-computed expectation for
// one instance: y_mealy for this cycle's inputs, and y_moore / match_count /
// busy as left by the previous edge.  The monitor pops on each falling edge.
module tb_seq_detector_param;
    import seq_det_pkg::*;

    typedef struct {
        int    dut;
        bit    mealy;
        bit    moore;
        int    cnt;
        bit    busy;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b0;
    logic x = 1'b0;
    logic clear = 1'b0;

    logic       m0, m1, m2;
    logic       mo0, mo1, mo2;
    logic       b0, b1, b2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .clock(clk), .reset_n(reset_n), .en(en), .x(x), .clear(clear),
        .y_mealy(m0), .y_moore(mo0), .match_count(c0), .busy(b0));

    seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_nov (
        .clock(clk), .reset_n(reset_n), .en(en), .x(x), .clear(clear),
        .y_mealy(m1), .y_moore(mo1), .match_count(c1), .busy(b1));

    seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (
        .clock(clk), .reset_n(reset_n), .en(en), .x(x), .clear(clear),
        .y_mealy(m2), .y_moore(mo2), .match_count(c2), .busy(b2));

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue its expectation.
    task automatic send(input int d, input bit r, input bit e, input bit xv, input bit c,
                        input bit em, input bit emo, input int ec, input bit eb, input string tag);
        @(posedge clk);
        #1;
        reset_n = r;
        en      = e;
        x       = xv;
        clear   = c;
        sb.push_back('{d, em, emo, ec, eb, tag});
        $display("issue  %-10s dut=%0d rst_n=%0b en=%0b x=%0b clr=%0b", tag, d, r, e, xv, c);
    endtask

    // Reset row: outputs of every instance drop asynchronously.
    task automatic rst_row(input int d, input string tag);
        send(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, tag);
    endtask

    // Stream 1,0,1,1,0,1,1 on an overlapping instance straight after reset.
    task automatic ov_stream(input int d, input string tag);
        bit xs[7]  = '{1, 0, 1, 1, 0, 1, 1};
        bit ym[7]  = '{0, 0, 0, 1, 0, 0, 1};
        bit ymo[7] = '{0, 0, 0, 0, 1, 0, 0};
        int cn[7]  = '{0, 0, 0, 0, 1, 1, 1};
        bit bz[7]  = '{0, 1, 1, 1, 1, 1, 1};
        for (int k = 0; k < 7; k++) begin
            send(d, 1'b1, 1'b1, xs[k], 1'b0, ym[k], ymo[k], cn[k], bz[k], $sformatf("%s_b%0d", tag, k + 1));
        end
    endtask

    // Monitor: compare the DUT against each queued expectation on the falling edge.
    initial begin : monitor
        exp_t e;
        int   am, amo, ac, ab;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                case (e.dut)
                    0:       begin am = int'(m0); amo = int'(mo0); ac = int'(c0); ab = int'(b0); end
                    1:       begin am = int'(m1); amo = int'(mo1); ac = int'(c1); ab = int'(b1); end
                    default: begin am = int'(m2); amo = int'(mo2); ac = int'(c2); ab = int'(b2); end
                endcase
                chk({e.tag, "/y_mealy"}, am, int'(e.mealy));
                chk({e.tag, "/y_moore"}, amo, int'(e.moore));
                chk({e.tag, "/count"}, ac, e.cnt);
                chk({e.tag, "/busy"}, ab, int'(e.busy));
                $display("check  %-10s dut=%0d mealy=%0d moore=%0d count=%0d busy=%0d", e.tag, e.dut, am, amo, ac, ab);
            end
        end
    end

    initial begin : stimulus
        // Border helper: 1011 reuses one bit, 1000 none.
        chk("border_1011", pattern_border(32'h0000_000B, 4), 1);
        chk("border_1000", pattern_border(32'h0000_0008, 4), 0);

        // A: overlapping detection, matches on bits 4 and 7.
        rst_row(0, "A_rst");
        ov_stream(0, "A");
        send(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, "A_idle1");
        send(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, "A_idle2");

        // B: non-overlapping detection, single match on bit 4.
        begin
            bit xs[7]  = '{1, 0, 1, 1, 0, 1, 1};
            bit ym[7]  = '{0, 0, 0, 1, 0, 0, 0};
            bit ymo[7] = '{0, 0, 0, 0, 1, 0, 0};
            int cn[7]  = '{0, 0, 0, 0, 1, 1, 1};
            bit bz[7]  = '{0, 1, 1, 1, 0, 1, 1};
            rst_row(1, "B_rst");
            for (int k = 0; k < 7; k++) begin
                send(1, 1'b1, 1'b1, xs[k], 1'b0, ym[k], ymo[k], cn[k], bz[k], $sformatf("B_b%0d", k + 1));
            end
            send(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, "B_idle");
            @(negedge clk);
            #1;
            chk("B_fill_after_b7", int'(dut_nov.fill_q), 3);
        end

        // C: same stream with three idle cycles after every bit.
        begin
            bit xs[7] = '{1, 0, 1, 1, 0, 1, 1};
            bit ym[7] = '{0, 0, 0, 1, 0, 0, 1};
            int cn[7] = '{0, 0, 0, 0, 1, 1, 1};
            bit bz[7] = '{0, 1, 1, 1, 1, 1, 1};
            rst_row(0, "C_rst");
            for (int k = 0; k < 7; k++) begin
                send(0, 1'b1, 1'b1, xs[k], 1'b0, ym[k], 1'b0, cn[k], bz[k], $sformatf("C_b%0d", k + 1));
                send(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ym[k], cn[k] + int'(ym[k]), 1'b1, $sformatf("C_g%0da", k + 1));
                send(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, cn[k] + int'(ym[k]), 1'b1, $sformatf("C_g%0db", k + 1));
                send(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cn[k] + int'(ym[k]), 1'b1, $sformatf("C_g%0dc", k + 1));
            end
        end

        // D: reset mid-prefix loses the partial 1,0,1.
        rst_row(0, "D_rst");
        send(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, "D_p1");
        send(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, "D_p2");
        send(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, "D_p3");
        send(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, "D_rstA");
        rst_row(0, "D_rstB");
        send(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, "D_q1");
        send(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, "D_q2");
        send(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, "D_q3");
        send(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, "D_q4");
        send(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, "D_q5");
        send(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, "D_idle");

        // E: 2-bit counter saturates at 3 over four overlapping matches.
        begin
            bit xs[13]  = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
            bit ym[13]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
            bit ymo[13] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
            int cn[13]  = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
            rst_row(2, "E_rst");
            for (int k = 0; k < 13; k++) begin
                send(2, 1'b1, 1'b1, xs[k], 1'b0, ym[k], ymo[k], cn[k], (k != 0), $sformatf("E_b%0d", k + 1));
            end
            send(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, "E_idle1");
            send(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, "E_idle2");
        end

        // F: clear on the cycle that would complete a third match.
        rst_row(0, "F_rst");
        ov_stream(0, "F");
        send(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, "F_b8");
        send(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, "F_b9");
        send(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b1, "F_clr");
        send(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, "F_after");
        send(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, "F_fresh");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        #2;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_detector_param
